// File: rtl/conv3x3_pe_pkg.sv
// Shared constants for the 3x3 convolution PE: kernel word indices and
// the accumulator width used between the adder tree and the output stage.
package conv3x3_pe_pkg;

    localparam int unsigned KWORDS    = 10;  // k1..k9 plus bias
    localparam int unsigned KIDX_BIAS = 9;
    localparam int unsigned KIDX_W    = 4;

    // Nine 2*DW products summed in two levels, plus bias headroom
    function automatic int unsigned acc_width(input int unsigned dw);
        return 2 * dw + 4;
    endfunction

endpackage

// File: rtl/conv3x3_pe_sat_relu.sv
// Output conditioning: drop fractional product bits, optional ReLU, and
// clamp to the signed DATA_WIDTH range. Purely combinational.
module sat_relu
    import conv3x3_pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int          RELU       = 1,
    parameter int unsigned ACC_W      = acc_width(DATA_WIDTH)
) (
    input  logic signed [ACC_W-1:0]      acc,
    output logic        [DATA_WIDTH-1:0] res
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    // Arithmetic shift truncates toward minus infinity, then clamp
    always_comb begin
        shifted = acc >>> FRAC_BITS;
        if ((RELU != 0) && shifted[ACC_W-1]) begin
            res = '0;
        end else if (shifted > SAT_MAX) begin
            res = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            res = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_pe.sv
// Pipelined 3x3 convolution PE: qualifies windows by pixel position,
// holds a serially loaded kernel, and produces one conditioned result
// per accepted window five cycles after its win_shift.
module conv3x3_pe
    import conv3x3_pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28,
    parameter int          RELU       = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] w1,
    input  logic [DATA_WIDTH-1:0] w2,
    input  logic [DATA_WIDTH-1:0] w3,
    input  logic [DATA_WIDTH-1:0] w4,
    input  logic [DATA_WIDTH-1:0] w5,
    input  logic [DATA_WIDTH-1:0] w6,
    input  logic [DATA_WIDTH-1:0] w7,
    input  logic [DATA_WIDTH-1:0] w8,
    input  logic [DATA_WIDTH-1:0] w9,
    input  logic                  win_shift,
    input  logic                  wt_valid,
    input  logic [DATA_WIDTH-1:0] wt_data,
    output logic                  kernel_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  frame_done
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W  = 2 * DATA_WIDTH + 2;
    localparam int unsigned ACC_W  = acc_width(DATA_WIDTH);
    localparam int unsigned COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic signed [DATA_WIDTH-1:0] tap   [9];
    logic signed [DATA_WIDTH-1:0] kword [KWORDS];
    logic [KIDX_W-1:0]            kidx;

    logic             shift_d;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             last_pos;

    logic                         s1_valid, s1_last;
    logic signed [PROD_W-1:0]     s1_prod [9];
    logic signed [DATA_WIDTH-1:0] s1_bias;
    logic                         s2_valid, s2_last;
    logic signed [SUM_W-1:0]      s2_row [3];
    logic signed [DATA_WIDTH-1:0] s2_bias;
    logic                         s3_valid, s3_last;
    logic signed [ACC_W-1:0]      s3_acc;
    logic [DATA_WIDTH-1:0]        sat_res;

    // Window taps as an indexable array, k-index order
    always_comb begin
        tap[0] = w1; tap[1] = w2; tap[2] = w3;
        tap[3] = w4; tap[4] = w5; tap[5] = w6;
        tap[6] = w7; tap[7] = w8; tap[8] = w9;
    end

    // A window needs two full rows/cols behind w9 and a complete kernel
    always_comb begin
        accept   = kernel_ready && (row >= ROW_W'(2)) && (col >= COL_W'(2));
        last_pos = (row == ROW_LAST) && (col == COL_LAST);
    end

    // Serial kernel load; a strobe on a complete kernel restarts at k1
    always_ff @(posedge CLK) begin
        if (RST) begin
            kidx         <= '0;
            kernel_ready <= 1'b0;
            for (int unsigned i = 0; i < KWORDS; i++) kword[i] <= '0;
        end else if (wt_valid) begin
            if (kernel_ready) begin
                kword[0]     <= wt_data;
                kidx         <= KIDX_W'(1);
                kernel_ready <= 1'b0;
            end else begin
                kword[kidx] <= wt_data;
                if (kidx == KIDX_W'(KIDX_BIAS)) begin
                    kidx         <= '0;
                    kernel_ready <= 1'b1;
                end else begin
                    kidx <= kidx + KIDX_W'(1);
                end
            end
        end
    end

    // Position of w9: advance on every shift_d after it has been evaluated
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_d <= 1'b0;
            col     <= '0;
            row     <= '0;
        end else begin
            shift_d <= win_shift;
            if (shift_d) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // S1 products, S2 row sums, S3 total plus bias, S4 conditioned output;
    // bias rides with the products so a reload cannot disturb in-flight work
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_bias    <= '0;
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s2_bias    <= '0;
            s3_valid   <= 1'b0;
            s3_last    <= 1'b0;
            s3_acc     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int unsigned i = 0; i < 9; i++) s1_prod[i] <= '0;
            for (int unsigned r = 0; r < 3; r++) s2_row[r] <= '0;
        end else begin
            s1_valid <= shift_d && accept;
            s1_last  <= shift_d && accept && last_pos;
            s1_bias  <= kword[KIDX_BIAS];
            for (int unsigned i = 0; i < 9; i++) begin
                s1_prod[i] <= PROD_W'(tap[i]) * PROD_W'(kword[i]);
            end

            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_bias  <= s1_bias;
            for (int unsigned r = 0; r < 3; r++) begin
                s2_row[r] <= SUM_W'(s1_prod[3*r]) + SUM_W'(s1_prod[3*r+1])
                           + SUM_W'(s1_prod[3*r+2]);
            end

            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            s3_acc   <= ACC_W'(s2_row[0]) + ACC_W'(s2_row[1]) + ACC_W'(s2_row[2])
                      + (ACC_W'(s2_bias) <<< FRAC_BITS);

            out_valid  <= s3_valid;
            frame_done <= s3_valid && s3_last;
            if (s3_valid) out_data <= sat_res;
        end
    end

    sat_relu #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .RELU       (RELU),
        .ACC_W      (ACC_W)
    ) u_sat_relu (
        .acc (s3_acc),
        .res (sat_res)
    );

endmodule

// File: tb/tb_conv3x3_pe.sv
// Directed bench for conv3x3_pe on a 5x5 image; one instance with ReLU,
// one without, sharing all inputs. The upstream line buffer is modelled
// by presenting the window of the pixel shifted in the previous cycle.
module tb_conv3x3_pe;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int NPIX = W * H;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic        win_shift, wt_valid;
    logic [15:0] wt_data;
    logic        kr1, ov1, fd1, kr0, ov0, fd0;
    logic [15:0] od1, od0;

    always #5 CLK = ~CLK;

    conv3x3_pe #(
        .DATA_WIDTH(16), .FRAC_BITS(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .RELU(1)
    ) dut_relu (
        .CLK(CLK), .RST(RST),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8), .w9(w9),
        .win_shift(win_shift), .wt_valid(wt_valid), .wt_data(wt_data),
        .kernel_ready(kr1), .out_data(od1), .out_valid(ov1), .frame_done(fd1)
    );

    conv3x3_pe #(
        .DATA_WIDTH(16), .FRAC_BITS(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .RELU(0)
    ) dut_lin (
        .CLK(CLK), .RST(RST),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8), .w9(w9),
        .win_shift(win_shift), .wt_valid(wt_valid), .wt_data(wt_data),
        .kernel_ready(kr0), .out_data(od0), .out_valid(ov0), .frame_done(fd0)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [15:0] q1_data[$];
    int          q1_cyc[$];
    logic        q1_fd[$];
    logic [15:0] q0_data[$];
    int          stray = 0;

    always @(negedge CLK) begin
        if (ov1) begin
            q1_data.push_back(od1);
            q1_cyc.push_back(cyc);
            q1_fd.push_back(fd1);
        end
        if (ov0) q0_data.push_back(od0);
        if ((fd1 && !ov1) || (fd0 && !ov0)) stray++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] img[NPIX];
    logic [15:0] kvals[10];
    logic [15:0] exp1[9];
    logic [15:0] exp0[9];
    int          shift_cyc[NPIX];

    function automatic logic [15:0] px(input int n);
        return (n >= 0 && n < NPIX) ? img[n] : 16'h0000;
    endfunction

    task automatic set_taps(input int n);
        w1 = px(n - 2*W - 2); w2 = px(n - 2*W - 1); w3 = px(n - 2*W);
        w4 = px(n - W - 2);   w5 = px(n - W - 1);   w6 = px(n - W);
        w7 = px(n - 2);       w8 = px(n - 1);       w9 = px(n);
    endtask

    task automatic clear_q();
        q1_data.delete(); q1_cyc.delete(); q1_fd.delete(); q0_data.delete();
    endtask

    // Loads kvals[first..last]; optionally checks the restart drop of kernel_ready
    task automatic load_words(input int first, input int last, input bit check_drop);
        for (int i = first; i <= last; i++) begin
            @(posedge CLK); #1;
            if (check_drop && i == first + 1) chk("restart_drop", kr1, 0);
            wt_valid = 1'b1;
            wt_data  = kvals[i];
        end
        @(posedge CLK); #1;
        wt_valid = 1'b0;
        chk($sformatf("kr_after_%0d", last), kr1, (last == 9) ? 1 : 0);
    endtask

    // Back-to-back win_shift for npix pixels; the trailing cycle has win_shift low
    task automatic send_frame(input int npix);
        int last = -1;
        for (int n = 0; n < npix; n++) begin
            @(posedge CLK); #1;
            win_shift = 1'b1;
            set_taps(last);
            shift_cyc[n] = cyc;
            last = n;
        end
        @(posedge CLK); #1;
        win_shift = 1'b0;
        set_taps(last);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_frame(input string name);
        chk({name, "_cnt_relu"}, q1_data.size(), 9);
        chk({name, "_cnt_lin"}, q0_data.size(), 9);
        for (int k = 0; k < 9; k++) begin
            if (k < q1_data.size()) begin
                chk($sformatf("%s_relu_%0d", name, k), q1_data[k], exp1[k]);
                chk($sformatf("%s_fd_%0d", name, k), q1_fd[k], (k == 8) ? 1 : 0);
                chk($sformatf("%s_lat_%0d", name, k),
                    q1_cyc[k] - shift_cyc[(2 + k / 3) * W + 2 + k % 3], 5);
            end
            if (k < q0_data.size())
                chk($sformatf("%s_lin_%0d", name, k), q0_data[k], exp0[k]);
        end
    endtask

    task automatic set_identity();
        kvals = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        for (int n = 0; n < NPIX; n++) img[n] = 16'(n * 256);
        exp1 = '{16'h0600, 16'h0700, 16'h0800, 16'h0B00, 16'h0C00,
                 16'h0D00, 16'h1000, 16'h1100, 16'h1200};
        exp0 = exp1;
    endtask

    task automatic fill_all(input logic [15:0] k, input logic [15:0] b, input logic [15:0] p,
                            input logic [15:0] e1, input logic [15:0] e0);
        for (int i = 0; i < 9; i++) kvals[i] = k;
        kvals[9] = b;
        for (int n = 0; n < NPIX; n++) img[n] = p;
        for (int i = 0; i < 9; i++) begin
            exp1[i] = e1;
            exp0[i] = e0;
        end
    endtask

    task automatic run_test(input string name);
        clear_q();
        send_frame(NPIX);
        idle(8);
        check_frame(name);
    endtask

    initial begin
        RST = 1'b1; win_shift = 1'b0; wt_valid = 1'b0; wt_data = '0;
        set_taps(-1);
        idle(3);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_od1", od1, 0); chk("rst_ov1", ov1, 0);
        chk("rst_fd1", fd1, 0); chk("rst_kr1", kr1, 0);
        chk("rst_od0", od0, 0); chk("rst_kr0", kr0, 0);

        set_identity();
        load_words(0, 9, 1'b0);
        run_test("ident");

        fill_all(16'h0100, 16'h0000, 16'h0100, 16'h0900, 16'h0900);
        load_words(0, 9, 1'b1);
        run_test("box");

        fill_all(16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        load_words(0, 9, 1'b1);
        run_test("satpos");

        fill_all(16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000);
        load_words(0, 9, 1'b1);
        run_test("satneg");

        fill_all(16'h0000, 16'hFF00, 16'h7FFF, 16'h0000, 16'hFF00);
        load_words(0, 9, 1'b1);
        run_test("bias");

        // Partial kernel: no output until the remaining words arrive
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        set_identity();
        load_words(0, 4, 1'b0);
        clear_q();
        send_frame(NPIX);
        idle(8);
        chk("partial_none_relu", q1_data.size(), 0);
        chk("partial_none_lin", q0_data.size(), 0);
        chk("partial_kr", kr1, 0);
        load_words(5, 9, 1'b0);
        run_test("partial");

        // Reset mid-frame with the first accepted window in flight
        clear_q();
        send_frame(13);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        chk("midrst_od", od1, 0); chk("midrst_ov", ov1, 0);
        chk("midrst_fd", fd1, 0); chk("midrst_kr", kr1, 0);
        idle(10);
        chk("midrst_none", q1_data.size(), 0);
        load_words(0, 9, 1'b0);
        run_test("afterrst");

        chk("stray_fd", stray, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
